// File: rtl/lsu_controller.sv
// Load/store unit sequencer: one memory access per execute-stage request, with
// store lane replication/strobes, load alignment and sign/zero extension.
module lsu_controller #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        is_store,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic [31:0] rdata,
  output logic        misaligned,
  output logic        bus_err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_wdata,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata
);

  localparam int CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE} state_t;

  state_t            state_q, state_d;
  logic              is_store_q, is_store_d;
  logic [2:0]        funct3_q, funct3_d;
  logic [31:0]       addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              misal_q, misal_d;
  logic              berr_q, berr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  // Illegal width codes and misaligned accesses both count as a fault.
  function automatic logic op_fault(input logic st, input logic [2:0] f3,
                                    input logic [1:0] a);
    logic illegal, mis;
    illegal = st ? (f3 > 3'd2) : ((f3 == 3'b011) || (f3[2:1] == 2'b11));
    mis     = ((f3[1:0] == 2'b01) && a[0]) || ((f3[1:0] == 2'b10) && (a != 2'b00));
    return illegal | mis;
  endfunction

  function automatic logic [31:0] load_extend(input logic [2:0] f3, input logic [1:0] a,
                                              input logic [31:0] rd);
    logic [31:0]        lane;
    logic signed [7:0]  b;
    logic signed [15:0] h;
    lane = rd >> {a, 3'b000};
    b    = lane[7:0];
    h    = lane[15:0];
    case (f3)
      3'b000:  return 32'(b);
      3'b001:  return 32'(h);
      3'b100:  return {24'd0, lane[7:0]};
      3'b101:  return {16'd0, lane[15:0]};
      default: return lane;
    endcase
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      is_store_q <= 1'b0;
      funct3_q   <= 3'd0;
      addr_q     <= 32'd0;
      wdata_q    <= 32'd0;
      rdata_q    <= 32'd0;
      misal_q    <= 1'b0;
      berr_q     <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      is_store_q <= is_store_d;
      funct3_q   <= funct3_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      misal_q    <= misal_d;
      berr_q     <= berr_d;
      cnt_q      <= cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    is_store_d = is_store_q;
    funct3_d   = funct3_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    misal_d    = misal_q;
    berr_d     = berr_q;
    cnt_d      = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          is_store_d = is_store;
          funct3_d   = funct3;
          addr_d     = addr;
          wdata_d    = wdata;
          rdata_d    = 32'd0;
          berr_d     = 1'b0;
          cnt_d      = '0;
          if (op_fault(is_store, funct3, addr[1:0])) begin
            state_d = S_DONE;
            misal_d = 1'b1;
          end else begin
            state_d = S_REQ;
            misal_d = 1'b0;
          end
        end
      end
      S_REQ: begin
        // A ready arriving on the limit cycle takes priority over the timeout.
        if (mem_ready) begin
          state_d = S_DONE;
          rdata_d = is_store_q ? 32'd0 : load_extend(funct3_q, addr_q[1:0], mem_rdata);
        end else if ((TIMEOUT_CYCLES != 0) && (cnt_q == CNT_LIMIT)) begin
          state_d = S_DONE;
          berr_d  = 1'b1;
          rdata_d = 32'd0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        rdata_d = 32'd0;
        misal_d = 1'b0;
        berr_d  = 1'b0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy       = (state_q != S_IDLE);
    done       = (state_q == S_DONE);
    mem_req    = (state_q == S_REQ);
    mem_we     = mem_req & is_store_q;
    mem_addr   = mem_req ? {addr_q[31:2], 2'b00} : 32'd0;
    mem_wstrb  = 4'd0;
    mem_wdata  = 32'd0;
    rdata      = rdata_q;
    misaligned = misal_q;
    bus_err    = berr_q;
    if (mem_we) begin
      case (funct3_q[1:0])
        2'b00: begin
          mem_wstrb = 4'b0001 << addr_q[1:0];
          mem_wdata = {4{wdata_q[7:0]}};
        end
        2'b01: begin
          mem_wstrb = 4'b0011 << {addr_q[1], 1'b0};
          mem_wdata = {2{wdata_q[15:0]}};
        end
        default: begin
          mem_wstrb = 4'b1111;
          mem_wdata = wdata_q;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_controller.sv
// Bench for lsu_controller: directed scenarios plus random loads/stores with
// random bus wait states, checked against a transaction-level model.
module tb_lsu_controller;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        is_store = 1'b0;
  logic [2:0]  funct3 = 3'd0;
  logic [31:0] addr = 32'd0;
  logic [31:0] wdata = 32'd0;
  logic        busy, done, misaligned, bus_err;
  logic [31:0] rdata;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ready = 1'b0;
  logic [31:0] mem_rdata = 32'd0;

  int n_cmp = 0;
  int n_bad = 0;

  lsu_controller #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .is_store(is_store),
    .funct3(funct3), .addr(addr), .wdata(wdata), .busy(busy), .done(done),
    .rdata(rdata), .misaligned(misaligned), .bus_err(bus_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata), .mem_ready(mem_ready),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // One transaction; entered and left #1 after a rising edge. ready comes on
  // REQ cycle waits+1; poke keeps junk start requests on the inputs while busy.
  task automatic run_op(input logic st, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, input logic [31:0] rd,
                        input int waits, input bit poke);
    int size, off, e_req, e_done, cyc, reqs;
    bit legal, fault, tmo, seen;
    logic [31:0] e_addr, e_wd, e_rd, sh;
    logic [3:0]  e_strb;

    off   = int'(a[1:0]);
    size  = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    legal = st ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    fault = !legal || ((a % size) != 0);
    tmo   = !fault && (waits >= TO);
    e_req = fault ? 0 : (tmo ? TO : waits + 1);
    e_done = fault ? 1 : e_req + 1;
    e_addr = a & ~32'h3;
    e_wd = 32'd0;
    e_strb = 4'd0;
    if (st) begin
      if (size == 1) begin e_wd = (wd & 32'hFF) * 32'h0101_0101; e_strb = 4'(1 << off); end
      else if (size == 2) begin e_wd = (wd & 32'hFFFF) * 32'h0001_0001; e_strb = 4'(3 << off); end
      else begin e_wd = wd; e_strb = 4'hF; end
    end
    sh = rd >> (8 * off);
    case (f3)
      3'd0:    e_rd = sh[7]  ? ((sh & 32'hFF) | 32'hFFFF_FF00) : (sh & 32'hFF);
      3'd1:    e_rd = sh[15] ? ((sh & 32'hFFFF) | 32'hFFFF_0000) : (sh & 32'hFFFF);
      3'd4:    e_rd = sh & 32'hFF;
      3'd5:    e_rd = sh & 32'hFFFF;
      default: e_rd = rd;
    endcase
    if (fault || tmo || st) e_rd = 32'd0;

    start = 1'b1; is_store = st; funct3 = f3; addr = a; wdata = wd;
    @(posedge clk); #1;
    cyc = 1; reqs = 0; seen = 0;
    while (!seen && cyc <= 20) begin
      if (done) begin
        seen = 1;
        check_eq("done_cycle", cyc, e_done);
        check_eq("req_cycles", reqs, e_req);
        check_eq("rdata", rdata, e_rd);
        check_eq("misaligned", misaligned, fault);
        check_eq("bus_err", bus_err, tmo);
        check_eq("req_in_done", mem_req, 1'b0);
        start = 1'b0; mem_ready = 1'b0;
      end else begin
        check_eq("busy", busy, 1'b1);
        if (mem_req) begin
          reqs++;
          check_eq("mem_addr", mem_addr, e_addr);
          check_eq("mem_we", mem_we, st);
          check_eq("mem_wstrb", mem_wstrb, e_strb);
          if (st) check_eq("mem_wdata", mem_wdata, e_wd);
          mem_ready = (reqs == waits + 1);
          mem_rdata = mem_ready ? rd : $urandom;
        end else begin
          mem_ready = 1'b0;
        end
        start = poke; is_store = 1'($urandom); funct3 = 3'($urandom);
        addr = $urandom; wdata = $urandom;
      end
      @(posedge clk); #1;
      cyc++;
    end
    if (!seen) check_eq("done_seen", 1'b0, 1'b1);
    start = 1'b0; mem_ready = 1'b0;
    check_eq("idle_busy", busy, 1'b0);
    check_eq("idle_done", done, 1'b0);
    check_eq("idle_flags", {misaligned, bus_err}, 2'b00);
    check_eq("idle_rdata", rdata, 32'd0);
  endtask

  initial begin
    #1;
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_done", done, 1'b0);
    check_eq("rst_req", mem_req, 1'b0);
    check_eq("rst_rdata", rdata, 32'd0);
    check_eq("rst_strb", mem_wstrb, 4'd0);
    check_eq("rst_flags", {misaligned, bus_err, mem_we}, 3'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    run_op(1'b0, 3'b000, 32'h1003, 32'h0, 32'h80FF_1234, 0, 1'b0);
    run_op(1'b0, 3'b101, 32'h2002, 32'h0, 32'hBEEF_0000, 3, 1'b0);
    run_op(1'b1, 3'b000, 32'h11, 32'hAABB_CCDD, 32'h0, 0, 1'b0);
    run_op(1'b1, 3'b001, 32'h12, 32'hAABB_CCDD, 32'h0, 1, 1'b0);
    run_op(1'b0, 3'b010, 32'h6, 32'h0, 32'h1234_5678, 0, 1'b1);
    run_op(1'b0, 3'b011, 32'h8, 32'h0, 32'h1234_5678, 0, 1'b1);
    run_op(1'b1, 3'b100, 32'h8, 32'h5, 32'h0, 0, 1'b0);
    run_op(1'b0, 3'b010, 32'h40, 32'h0, 32'hCAFE_F00D, 10, 1'b1);
    run_op(1'b1, 3'b010, 32'h44, 32'h1122_3344, 32'h0, 2, 1'b1);

    // Reset in the middle of a request.
    start = 1'b1; is_store = 1'b0; funct3 = 3'b010; addr = 32'h80; wdata = 32'd0;
    @(posedge clk); #1;
    start = 1'b0; mem_ready = 1'b0;
    check_eq("pre_rst_req", mem_req, 1'b1);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check_eq("async_req", mem_req, 1'b0);
    check_eq("async_busy", busy, 1'b0);
    repeat (2) begin
      @(posedge clk); #1;
      check_eq("rst_no_done", done, 1'b0);
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    run_op(1'b0, 3'b010, 32'h0, 32'h0, 32'h0BAD_BEEF, 0, 1'b0);

    for (int i = 0; i < 150; i++) begin
      run_op(1'($urandom), 3'($urandom), $urandom, $urandom, $urandom,
             int'($urandom_range(0, 5)), 1'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
